// File: rtl/segre_icache.sv
// Direct-mapped, read-only instruction cache with a zero-latency hit path
// and a single-beat whole-line refill from instruction memory.
module segre_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fetch_req_i,
    input  logic [ADDR_WIDTH-1:0]      pc_i,
    input  logic                       flush_i,
    output logic                       hit_o,
    output logic [31:0]                instr_o,
    output logic                       mem_rd_req_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    input  logic                       mem_ready_i,
    input  logic [32*LINE_WORDS-1:0]   mem_data_i,
    output logic [15:0]                miss_count_o
);

    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic {
        LOOKUP,
        REFILL
    } state_t;

    state_t                  r_state;
    logic [NUM_LINES-1:0]    r_valid;
    logic                    r_drop;
    logic [ADDR_WIDTH-1:0]   r_memAddr;
    logic [15:0]             r_missCount;
    logic [TAG_W-1:0]        r_tagArray  [NUM_LINES];
    logic [31:0]             r_dataArray [NUM_LINES][LINE_WORDS];

    logic [ADDR_WIDTH-1:0]   w_lineAddr;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [WORD_W-1:0]       w_word;
    logic [IDX_W-1:0]        w_fillIdx;
    logic [TAG_W-1:0]        w_fillTag;
    logic                    w_hit;
    logic                    w_miss;
    logic                    w_fill;

    assign w_lineAddr = pc_i & LINE_MASK;
    assign w_idx      = pc_i[OFF_W+IDX_W-1:OFF_W];
    assign w_tag      = pc_i[ADDR_WIDTH-1:OFF_W+IDX_W];
    assign w_word     = pc_i[OFF_W-1:2];

    // The refill address already carries the latched index and tag.
    assign w_fillIdx  = r_memAddr[OFF_W+IDX_W-1:OFF_W];
    assign w_fillTag  = r_memAddr[ADDR_WIDTH-1:OFF_W+IDX_W];

    assign w_hit  = (r_state == LOOKUP) && fetch_req_i && !flush_i &&
                    r_valid[w_idx] && (r_tagArray[w_idx] == w_tag);
    assign w_miss = (r_state == LOOKUP) && fetch_req_i && !w_hit;
    assign w_fill = (r_state == REFILL) && mem_ready_i;

    assign hit_o        = w_hit;
    assign instr_o      = w_hit ? r_dataArray[w_idx][w_word] : 32'd0;
    assign mem_rd_req_o = (r_state == REFILL);
    assign mem_addr_o   = r_memAddr;
    assign miss_count_o = r_missCount;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= LOOKUP;
            r_valid     <= '0;
            r_drop      <= 1'b0;
            r_memAddr   <= '0;
            r_missCount <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= '0;
            end
            case (r_state)
                LOOKUP: begin
                    if (w_miss) begin
                        r_state   <= REFILL;
                        r_memAddr <= w_lineAddr;
                        if (r_missCount != 16'hFFFF) begin
                            r_missCount <= r_missCount + 16'd1;
                        end
                    end
                end
                REFILL: begin
                    // A flush seen at any point of the refill keeps the arriving line invalid.
                    if (mem_ready_i) begin
                        r_valid[w_fillIdx] <= !(r_drop || flush_i);
                        r_drop             <= 1'b0;
                        r_state            <= LOOKUP;
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tagArray[w_fillIdx] <= w_fillTag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_dataArray[w_fillIdx][k] <= mem_data_i[32*k +: 32];
            end
        end
    end

endmodule
